// File: rtl/extend_arbiter.sv
// extend_arbiter: round-robin arbiter that shares a single 16->32-bit
// zero/sign extension unit among NREQ requesters. The granted result is
// registered, along with the winner's ID, behind a valid/ready handshake.

// Shared extension unit: zero extension when sext=0, sign extension when sext=1.
module extend (
   input  logic [15:0] a,
   input  logic        sext,
   output logic [31:0] b
);

   assign b = {{16{a[15] & sext}}, a};

endmodule

module extend_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [16*NREQ-1:0]   a_in,
   input  logic [NREQ-1:0]      sext_in,
   output logic [NREQ-1:0]      gnt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [IDW-1:0]       out_id,
   output logic [7:0]           busy_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [31:0]      data_q, data_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [7:0]       busy_q, busy_d;

   logic             can_accept;
   logic             found;
   logic             grant;
   logic [IDW-1:0]   winner;
   int unsigned      idx;
   logic [15:0]      sel_a;
   logic             sel_sext;
   logic [31:0]      ext_b;

   // Round-robin search starting at ptr; the first set request bit wins.
   always_comb begin
      can_accept = (state_q == EMPTY) || out_ready;
      found      = 1'b0;
      winner     = '0;
      idx        = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx[IDW-1:0];
         end
      end
      grant = can_accept && found;
      gnt   = '0;
      // gnt is forced low while reset is asserted, independent of the flops.
      if (rst_n && grant) begin
         gnt[winner] = 1'b1;
      end
   end

   // Route the winner's immediate and mode into the shared extend unit.
   always_comb begin
      sel_a    = a_in[16*int'(winner) +: 16];
      sel_sext = sext_in[winner];
   end

   extend u_extend (
      .a    (sel_a),
      .sext (sel_sext),
      .b    (ext_b)
   );

   // Next-state logic for the result register, pointer and stall counter.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      id_d    = id_q;
      busy_d  = busy_q;

      case (state_q)
         EMPTY: begin
            if (grant) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (grant) begin
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (grant) begin
         data_d = ext_b;
         id_d   = winner;
         ptr_d  = ((int'(winner) + 1) % NREQ) == 0 ? '0 : winner + 1'b1;
      end

      if ((|req) && !can_accept && (busy_q != 8'hFF)) begin
         busy_d = busy_q + 8'd1;
      end
   end

   // Register state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         id_q    <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_id    = id_q;
   assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_extend_arbiter.sv
// Testbench for extend_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the arbiter.
`timescale 1ns/1ps
module tb_extend_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [16*NREQ-1:0]   a_in;
   logic [NREQ-1:0]      sext_in;
   logic [NREQ-1:0]      gnt;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_data;
   logic [IDW-1:0]       out_id;
   logic [7:0]           busy_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state.
   bit          m_valid;
   int          m_ptr;
   logic [31:0] m_data;
   int          m_id;
   int          m_busy;

   extend_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .a_in      (a_in),
      .sext_in   (sext_in),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id),
      .busy_cnt  (busy_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // Called on a falling edge: asserts reset asynchronously, checks the
   // immediate effect, then releases it well before the next rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_id", 32'(out_id), 32'd0);
      check("rst_busy", 32'(busy_cnt), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      m_valid = 0; m_ptr = 0; m_data = '0; m_id = 0; m_busy = 0;
      rst_n = 1'b1;
      #1;
   endtask

   // One clock cycle: inputs are already driven; check gnt, clock, check outputs.
   task automatic step();
      int              w;
      bit              can;
      logic [NREQ-1:0] eg;
      logic [15:0]     a;
      #1;
      can = !m_valid || out_ready;
      w = -1;
      if (can) begin
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         end
      end
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      check("gnt", 32'(gnt), 32'(eg));
      @(posedge clk);
      if (w >= 0) begin
         a = a_in[16*w +: 16];
         m_data  = sext_in[w] ? 32'($signed(a)) : 32'(a);
         m_id    = w;
         m_valid = 1;
         m_ptr   = (w + 1) % NREQ;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      if (req != 0 && !can && m_busy < 255) m_busy++;
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data", out_data, m_data);
      check("out_id", 32'(out_id), 32'(m_id));
      check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
   endtask

   initial begin
      rst_n = 1'b0; req = '0; a_in = '0; sext_in = '0; out_ready = 1'b0;
      m_valid = 0; m_ptr = 0; m_data = '0; m_id = 0; m_busy = 0;
      @(negedge clk);
      do_reset();

      // Single requester, sign and zero extension of 0x8000.
      out_ready = 1'b1; req = 4'b0001; a_in[15:0] = 16'h8000; sext_in[0] = 1'b1;
      step();
      check("sx8000", out_data, 32'hFFFF8000);
      sext_in[0] = 1'b0;
      step();
      check("zx8000", out_data, 32'h00008000);

      // Requester 2 with all-ones immediate.
      req = 4'b0100; a_in[47:32] = 16'hFFFF; sext_in[2] = 1'b1;
      step();
      check("sxFFFF", out_data, 32'hFFFFFFFF);
      check("id2", 32'(out_id), 32'd2);
      sext_in[2] = 1'b0;
      step();
      check("zxFFFF", out_data, 32'h0000FFFF);

      // Fairness: all requesting from ptr=0 gives 0,1,2,3,0 with no bubbles.
      do_reset();
      req = 4'b1111; sext_in = '0;
      for (int i = 0; i < NREQ; i++) a_in[16*i +: 16] = 16'(i + 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("rr_id", 32'(out_id), 32'(i % NREQ));
         check("rr_data", out_data, 32'((i % NREQ) + 1));
      end

      // Backpressure: pending result held for 5 stalled cycles.
      do_reset();
      req = 4'b0010; a_in[31:16] = 16'h1234; sext_in[1] = 1'b0;
      step();
      out_ready = 1'b0; a_in[31:16] = 16'h5678;
      for (int i = 0; i < 5; i++) step();
      check("bp_busy5", 32'(busy_cnt), 32'd5);
      check("bp_hold", out_data, 32'h00001234);
      out_ready = 1'b1;
      step();
      check("bp_refill_valid", 32'(out_valid), 32'd1);
      check("bp_refill_data", out_data, 32'h00005678);

      // Saturation of the stall counter.
      out_ready = 1'b0; req = 4'b0001;
      for (int i = 0; i < 260; i++) step();
      check("busy_sat", 32'(busy_cnt), 32'd255);

      // Mid-stream reset with ptr=2 and a pending result.
      do_reset();
      out_ready = 1'b1; req = 4'b0010;
      step();
      req = '0; out_ready = 1'b0;
      do_reset();
      req = 4'b1100; out_ready = 1'b1; a_in[47:32] = 16'h00AA;
      step();
      check("post_rst_id", 32'(out_id), 32'd2);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         req       = NREQ'($urandom);
         a_in      = {$urandom, $urandom};
         sext_in   = NREQ'($urandom);
         out_ready = ($urandom % 4) != 0;
         if ($urandom % 200 == 0) do_reset();
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
